glink_rx_monitor: RTL and testbench
===================================

Name: glink_rx_monitor

Overview:
Parametrised receive-side monitor for the DDU gigabit link (TLK), and the successor to the fixed 2-bit error/DAV counters on the rxclk domain. It registers the raw receive bus, keeps saturating or wrapping event counters, and tracks framing with a start/end-word state machine. It also runs a windowed error-rate detector that flags a bad link, and offers a snapshot/clear handshake for JTAG status readout.

Parameters:
DW, 16, width of receive data bus
CNT_W, 16, width of DAV, error, good-frame and bad-frame counters
LEN_W, 10, width of frame-length counter; max legal frame length is 2^LEN_W-1 words
WIN_W, 12, error window is 2^WIN_W rxclk cycles
ERR_THRESH, 8, errors within one window that assert LINK_BAD (1..2^WIN_W)
SATURATE, 1, 1 = counters hold at all-ones; 0 = counters wrap to 0
CLR_ON_SNAP, 1, 1 = live counters are cleared when a snapshot is taken
SOF_WORD, 16'hF7F7, start-of-frame word
EOF_WORD, 16'hFEFE, end-of-frame word

Ports:
rxclk  in  1  receive clock
rst  in  1  asynchronous active-high reset
GLRD  in  DW  raw receive data
GRXERR  in  1  raw receive error
GRXDAV  in  1  raw receive data valid
SNAP  in  1  single-cycle snapshot request, rxclk-synchronous
SNAP_VALID  out  1  one-cycle strobe when snapshot outputs have updated
DAV_CNT  out  CNT_W  snapshot of data-valid word count
ERR_CNT  out  CNT_W  snapshot of error-cycle count
GOOD_FRM  out  CNT_W  snapshot of good-frame count
BAD_FRM  out  CNT_W  snapshot of bad-frame count
MAX_LEN  out  LEN_W  snapshot of longest good frame, in words including SOF/EOF
IN_FRAME  out  1  live: FSM is in the FRAME state
LINK_BAD  out  1  live: error-rate flag
FRM_DONE  out  1  live one-cycle pulse when a good frame completes

Behaviour:
- Reset and clocking: rst is asynchronous, active-high; clock is rxclk. On reset every register and output is 0 and the FSM is in IDLE.
- Input stage: GLRD, GRXERR and GRXDAV are registered into d_r, e_r and v_r (IOB). All other logic uses only these registered values, so event latency is 1 cycle from the pins to the counters.
- Counter update: dav_cnt increments on v_r; err_cnt increments on e_r. With SATURATE=1, a counter at all-ones stays there; with SATURATE=0 it wraps to 0. good_frm and bad_frm follow the same rule.
- Frame FSM, IDLE state:
  - v_r & ~e_r & d_r==SOF_WORD -> FRAME, len=1.
  - Any other word is ignored.
- Frame FSM, FRAME state, one event per cycle, highest priority first:
  1. e_r: bad_frm++ and go to IDLE. This applies whether or not v_r is set.
  2. v_r & d_r==SOF_WORD: bad_frm++, stay in FRAME, len=1 (resync).
  3. v_r & d_r==EOF_WORD: good_frm++, max_len=max(max_len, len+1), FRM_DONE=1 for one cycle, go to IDLE.
  4. v_r & len==2^LEN_W-2: bad_frm++, go to IDLE. The frame exceeds the maximum length without an EOF.
  5. v_r otherwise: len++.
- IN_FRAME is 1 exactly while the FSM is in FRAME. FRM_DONE is registered and asserts in the cycle after the EOF word is seen in d_r.
- Error window:
  - win_cnt is a WIN_W-bit free-running counter; werr counts e_r inside the current window and saturates at ERR_THRESH.
  - When werr reaches ERR_THRESH, LINK_BAD=1 on the next cycle.
  - At window rollover (win_cnt all-ones), werr reloads with e_r of that cycle.
  - LINK_BAD clears at a rollover only if werr==0 for the window that just ended. Recovery therefore needs one full clean window.
- Snapshot:
  - When SNAP=1, the live counters and max_len (including any increment in the same cycle) are copied to the outputs on the next edge, and SNAP_VALID pulses for that single cycle.
  - With CLR_ON_SNAP=1, the live counters and max_len clear on that same edge. Events in the SNAP cycle go into the snapshot, not the new period, so no event is lost.
  - The FSM, len, window logic and LINK_BAD are not affected by SNAP.
  - Back-to-back SNAP is legal; each one produces a SNAP_VALID.
- Reset mid-frame aborts the frame without counting it as bad.

Test Plan:
- Frame: reset, send SOF, 3 data words, EOF with GRXDAV=1, then SNAP -> GOOD_FRM=1, BAD_FRM=0, MAX_LEN=5, DAV_CNT=5, FRM_DONE pulses once, IN_FRAME high for 4 cycles.
- Abort: SOF, 2 data words, GRXERR for 1 cycle, then SNAP -> BAD_FRM=1, GOOD_FRM=0, ERR_CNT=1, IN_FRAME low the cycle after the error.
- Resync and overlength: with LEN_W=4, send SOF, SOF, 20 data words, then SNAP -> BAD_FRM=2 (one resync, one overlength), GOOD_FRM=0.
- Saturation: with CNT_W=4 and SATURATE=1, send 20 DAV cycles -> DAV_CNT=15. Repeat with SATURATE=0 -> DAV_CNT=4.
- Window: with WIN_W=6 and ERR_THRESH=8, inject 8 errors in one window -> LINK_BAD=1. It stays 1 through the next window containing 1 error, then clears after the following error-free window.
- Snapshot-clear race: raise GRXDAV so a count lands in the same cycle as SNAP, with CLR_ON_SNAP=1 -> that word is in the DAV_CNT snapshot, the live count is 0 afterwards, and a second SNAP with no traffic returns 0.

Source files
------------

// File: rtl/glink_rx_monitor.sv
// Receive-side monitor for the DDU gigabit link: registered input stage, event
// counters, SOF/EOF framing FSM, windowed error-rate flag and snapshot/clear readout.

module glink_evt_cnt #(
    parameter int W        = 16,
    parameter int SATURATE = 1
) (
    input  logic         rxclk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] nxt
);
    logic [W-1:0] cnt;

    always_comb begin
        nxt = cnt;
        if (inc && !((SATURATE != 0) && (&cnt)))
            nxt = cnt + 1'b1;
    end

    // nxt is exported so a snapshot captures the same-cycle increment
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else          cnt <= nxt;
    end
endmodule

module glink_rx_monitor #(
    parameter int             DW          = 16,
    parameter int             CNT_W       = 16,
    parameter int             LEN_W       = 10,
    parameter int             WIN_W       = 12,
    parameter int             ERR_THRESH  = 8,
    parameter int             SATURATE    = 1,
    parameter int             CLR_ON_SNAP = 1,
    parameter logic [DW-1:0]  SOF_WORD    = 16'hF7F7,
    parameter logic [DW-1:0]  EOF_WORD    = 16'hFEFE
) (
    input  logic             rxclk,
    input  logic             rst,
    input  logic [DW-1:0]    GLRD,
    input  logic             GRXERR,
    input  logic             GRXDAV,
    input  logic             SNAP,
    output logic             SNAP_VALID,
    output logic [CNT_W-1:0] DAV_CNT,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] GOOD_FRM,
    output logic [CNT_W-1:0] BAD_FRM,
    output logic [LEN_W-1:0] MAX_LEN,
    output logic             IN_FRAME,
    output logic             LINK_BAD,
    output logic             FRM_DONE
);
    localparam int NCNT   = 4;
    localparam int CI_DAV = 0;
    localparam int CI_ERR = 1;
    localparam int CI_GD  = 2;
    localparam int CI_BAD = 3;
    localparam int WE_W   = $clog2(ERR_THRESH + 1);
    localparam logic [WE_W-1:0]  THR     = WE_W'(ERR_THRESH);
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_LIM = {{(LEN_W-1){1'b1}}, 1'b0};

    typedef enum logic {IDLE, FRAME} state_t;

    logic [DW-1:0] d_r;
    logic          e_r, v_r;

    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            d_r <= '0;
            e_r <= 1'b0;
            v_r <= 1'b0;
        end else begin
            d_r <= GLRD;
            e_r <= GRXERR;
            v_r <= GRXDAV;
        end
    end

    // Frame FSM
    state_t           state, state_nxt;
    logic [LEN_W-1:0] len, len_nxt;
    logic             good_inc, bad_inc, done_nxt;

    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len      <= '0;
            FRM_DONE <= 1'b0;
        end else begin
            state    <= state_nxt;
            len      <= len_nxt;
            FRM_DONE <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        good_inc  = 1'b0;
        bad_inc   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (v_r && !e_r && d_r == SOF_WORD) begin
                    state_nxt = FRAME;
                    len_nxt   = LEN_ONE;
                end
            end
            FRAME: begin
                if (e_r) begin
                    bad_inc   = 1'b1;
                    state_nxt = IDLE;
                end else if (v_r) begin
                    if (d_r == SOF_WORD) begin
                        bad_inc = 1'b1;
                        len_nxt = LEN_ONE;
                    end else if (d_r == EOF_WORD) begin
                        good_inc  = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (len == LEN_LIM) begin
                        // one more non-EOF word would exceed the legal length
                        bad_inc   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        len_nxt = len + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign IN_FRAME = (state == FRAME);

    // Event counters
    logic                       snap_clr;
    logic [NCNT-1:0]            cnt_inc;
    logic [NCNT-1:0][CNT_W-1:0] cnt_nxt;

    assign snap_clr = SNAP && (CLR_ON_SNAP != 0);

    always_comb begin
        cnt_inc         = '0;
        cnt_inc[CI_DAV] = v_r;
        cnt_inc[CI_ERR] = e_r;
        cnt_inc[CI_GD]  = good_inc;
        cnt_inc[CI_BAD] = bad_inc;
    end

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        glink_evt_cnt #(.W(CNT_W), .SATURATE(SATURATE)) u_cnt (
            .rxclk (rxclk),
            .rst   (rst),
            .inc   (cnt_inc[g]),
            .clr   (snap_clr),
            .nxt   (cnt_nxt[g])
        );
    end

    logic [LEN_W-1:0] max_len, max_nxt, frm_len;

    assign frm_len = len + 1'b1;
    assign max_nxt = (good_inc && frm_len > max_len) ? frm_len : max_len;

    always_ff @(posedge rxclk or posedge rst) begin
        if (rst)           max_len <= '0;
        else if (snap_clr) max_len <= '0;
        else               max_len <= max_nxt;
    end

    // Snapshot registers
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            SNAP_VALID <= 1'b0;
            DAV_CNT    <= '0;
            ERR_CNT    <= '0;
            GOOD_FRM   <= '0;
            BAD_FRM    <= '0;
            MAX_LEN    <= '0;
        end else begin
            SNAP_VALID <= SNAP;
            if (SNAP) begin
                DAV_CNT  <= cnt_nxt[CI_DAV];
                ERR_CNT  <= cnt_nxt[CI_ERR];
                GOOD_FRM <= cnt_nxt[CI_GD];
                BAD_FRM  <= cnt_nxt[CI_BAD];
                MAX_LEN  <= max_nxt;
            end
        end
    end

    // Error-rate window; recovery needs a whole window with werr==0
    logic [WIN_W-1:0] win_cnt;
    logic [WE_W-1:0]  werr;
    logic             win_end;

    assign win_end = &win_cnt;

    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            win_cnt  <= '0;
            werr     <= '0;
            LINK_BAD <= 1'b0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            if (win_end)
                werr <= {{(WE_W-1){1'b0}}, e_r};
            else if (e_r && werr != THR)
                werr <= werr + 1'b1;
            if (werr == THR)
                LINK_BAD <= 1'b1;
            else if (win_end && werr == '0)
                LINK_BAD <= 1'b0;
        end
    end
endmodule

// File: tb/tb_glink_rx_monitor.sv
// Directed bench for glink_rx_monitor: four instances with different parameter
// sets share one stimulus stream; expected values are hand-computed.

module tb_glink_rx_monitor;
    logic        rxclk = 1'b0;
    logic        rst   = 1'b1;
    logic [15:0] GLRD  = '0;
    logic        GRXERR = 1'b0, GRXDAV = 1'b0, SNAP = 1'b0;

    always #5 rxclk = ~rxclk;

    // u0: defaults
    logic        sv0, inf0, lb0, fd0;
    logic [15:0] dav0, err0, good0, bad0;
    logic [9:0]  max0;
    // u1: LEN_W=4, WIN_W=6
    logic        sv1, inf1, lb1, fd1;
    logic [15:0] dav1, err1, good1, bad1;
    logic [3:0]  max1;
    // u2: CNT_W=4 saturating, u3: CNT_W=4 wrapping
    logic        sv2, inf2, lb2, fd2, sv3, inf3, lb3, fd3;
    logic [3:0]  dav2, err2, good2, bad2, dav3, err3, good3, bad3;
    logic [9:0]  max2, max3;

    glink_rx_monitor u0 (
        .rxclk(rxclk), .rst(rst), .GLRD(GLRD), .GRXERR(GRXERR), .GRXDAV(GRXDAV), .SNAP(SNAP),
        .SNAP_VALID(sv0), .DAV_CNT(dav0), .ERR_CNT(err0), .GOOD_FRM(good0), .BAD_FRM(bad0),
        .MAX_LEN(max0), .IN_FRAME(inf0), .LINK_BAD(lb0), .FRM_DONE(fd0));

    glink_rx_monitor #(.LEN_W(4), .WIN_W(6), .ERR_THRESH(8)) u1 (
        .rxclk(rxclk), .rst(rst), .GLRD(GLRD), .GRXERR(GRXERR), .GRXDAV(GRXDAV), .SNAP(SNAP),
        .SNAP_VALID(sv1), .DAV_CNT(dav1), .ERR_CNT(err1), .GOOD_FRM(good1), .BAD_FRM(bad1),
        .MAX_LEN(max1), .IN_FRAME(inf1), .LINK_BAD(lb1), .FRM_DONE(fd1));

    glink_rx_monitor #(.CNT_W(4), .SATURATE(1)) u2 (
        .rxclk(rxclk), .rst(rst), .GLRD(GLRD), .GRXERR(GRXERR), .GRXDAV(GRXDAV), .SNAP(SNAP),
        .SNAP_VALID(sv2), .DAV_CNT(dav2), .ERR_CNT(err2), .GOOD_FRM(good2), .BAD_FRM(bad2),
        .MAX_LEN(max2), .IN_FRAME(inf2), .LINK_BAD(lb2), .FRM_DONE(fd2));

    glink_rx_monitor #(.CNT_W(4), .SATURATE(0)) u3 (
        .rxclk(rxclk), .rst(rst), .GLRD(GLRD), .GRXERR(GRXERR), .GRXDAV(GRXDAV), .SNAP(SNAP),
        .SNAP_VALID(sv3), .DAV_CNT(dav3), .ERR_CNT(err3), .GOOD_FRM(good3), .BAD_FRM(bad3),
        .MAX_LEN(max3), .IN_FRAME(inf3), .LINK_BAD(lb3), .FRM_DONE(fd3));

    int n_cmp = 0;
    int n_mis = 0;
    int edge_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive pins, take one rising edge, settle 1 time unit past it
    task automatic cyc(input logic [15:0] d, input logic e, input logic v, input logic s);
        GLRD = d; GRXERR = e; GRXDAV = v; SNAP = s;
        @(posedge rxclk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) cyc(16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        GLRD = '0; GRXERR = 1'b0; GRXDAV = 1'b0; SNAP = 1'b0;
        repeat (2) @(posedge rxclk);
        #1;
        rst = 1'b0;
        edge_n = 0;
    endtask

    localparam logic [15:0] SOF = 16'hF7F7;
    localparam logic [15:0] EOF = 16'hFEFE;

    initial begin
        logic [15:0] fw [0:6];
        int inf_n, fd_n;

        // Reset state
        do_reset();
        chk("rst_snap_valid", 32'(sv0), 0);
        chk("rst_dav_cnt",    32'(dav0), 0);
        chk("rst_bad_frm",    32'(bad0), 0);
        chk("rst_max_len",    32'(max0), 0);
        chk("rst_in_frame",   32'(inf0), 0);
        chk("rst_link_bad",   32'(lb1), 0);
        chk("rst_frm_done",   32'(fd0), 0);

        // Good frame: SOF, 3 data, EOF
        fw = '{SOF, 16'h0011, 16'h0022, 16'h0033, EOF, 16'h0000, 16'h0000};
        inf_n = 0; fd_n = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(fw[i], 1'b0, (i < 5), 1'b0);
            inf_n += int'(inf0);
            fd_n  += int'(fd0);
        end
        chk("frame_in_frame_cycles", 32'(inf_n), 4);
        chk("frame_frm_done_pulses", 32'(fd_n), 1);
        cyc(16'h0000, 1'b0, 1'b0, 1'b1);
        chk("frame_snap_valid", 32'(sv0), 1);
        chk("frame_good_frm",   32'(good0), 1);
        chk("frame_bad_frm",    32'(bad0), 0);
        chk("frame_max_len",    32'(max0), 5);
        chk("frame_dav_cnt",    32'(dav0), 5);
        chk("frame_err_cnt",    32'(err0), 0);
        cyc(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("frame_snap_valid_drop", 32'(sv0), 0);

        // Abort by error mid-frame
        do_reset();
        cyc(SOF,       1'b0, 1'b1, 1'b0);
        cyc(16'h0101,  1'b0, 1'b1, 1'b0);
        cyc(16'h0202,  1'b0, 1'b1, 1'b0);
        cyc(16'h0000,  1'b1, 1'b0, 1'b0);
        chk("abort_in_frame_before", 32'(inf0), 1);
        cyc(16'h0000,  1'b0, 1'b0, 1'b0);
        chk("abort_in_frame_after",  32'(inf0), 0);
        cyc(16'h0000,  1'b0, 1'b0, 1'b1);
        chk("abort_bad_frm",  32'(bad0), 1);
        chk("abort_good_frm", 32'(good0), 0);
        chk("abort_err_cnt",  32'(err0), 1);
        chk("abort_dav_cnt",  32'(dav0), 3);

        // Resync plus overlength (u1 LEN_W=4; u0 only sees the resync)
        do_reset();
        cyc(SOF, 1'b0, 1'b1, 1'b0);
        cyc(SOF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(16'h0100 + 16'(i), 1'b0, 1'b1, 1'b0);
        cyc(16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("ovl_u1_in_frame", 32'(inf1), 0);
        chk("ovl_u0_in_frame", 32'(inf0), 1);
        cyc(16'h0000, 1'b0, 1'b0, 1'b1);
        chk("ovl_u1_bad_frm",  32'(bad1), 2);
        chk("ovl_u1_good_frm", 32'(good1), 0);
        chk("ovl_u1_dav_cnt",  32'(dav1), 22);
        chk("ovl_u0_bad_frm",  32'(bad0), 1);

        // Longest legal frame for LEN_W=4: 15 words
        do_reset();
        cyc(SOF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) cyc(16'h0200 + 16'(i), 1'b0, 1'b1, 1'b0);
        cyc(EOF, 1'b0, 1'b1, 1'b0);
        cyc(16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(16'h0000, 1'b0, 1'b0, 1'b1);
        chk("maxlen_u1_good_frm", 32'(good1), 1);
        chk("maxlen_u1_bad_frm",  32'(bad1), 0);
        chk("maxlen_u1_max_len",  32'(max1), 15);
        chk("maxlen_u0_max_len",  32'(max0), 15);

        // Saturating vs wrapping 4-bit counters
        do_reset();
        for (int i = 0; i < 20; i++) cyc(16'h0000, 1'b0, 1'b1, 1'b0);
        cyc(16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(16'h0000, 1'b0, 1'b0, 1'b1);
        chk("sat_dav_cnt",  32'(dav2), 15);
        chk("wrap_dav_cnt", 32'(dav3), 4);

        // Snapshot/clear race and back-to-back SNAP
        do_reset();
        cyc(16'h0000, 1'b0, 1'b1, 1'b0);
        cyc(16'h0000, 1'b0, 1'b1, 1'b0);
        cyc(16'h0000, 1'b0, 1'b0, 1'b1);
        chk("race_snap_valid", 32'(sv0), 1);
        chk("race_dav_cnt",    32'(dav0), 2);
        cyc(16'h0000, 1'b0, 1'b0, 1'b1);
        chk("b2b_snap_valid",  32'(sv0), 1);
        chk("b2b_dav_cnt",     32'(dav0), 0);
        cyc(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("b2b_snap_valid_drop", 32'(sv0), 0);

        // Error window on u1 (64-cycle windows, rollover at edges 64/128/192)
        do_reset();
        run_to(4);
        chk("win_link_bad_clean", 32'(lb1), 0);
        for (int i = 0; i < 8; i++) cyc(16'h0000, 1'b1, 1'b0, 1'b0);
        run_to(20);
        chk("win_link_bad_set", 32'(lb1), 1);
        run_to(89);
        cyc(16'h0000, 1'b1, 1'b0, 1'b0);
        run_to(130);
        chk("win_link_bad_hold1", 32'(lb1), 1);
        run_to(185);
        chk("win_link_bad_hold2", 32'(lb1), 1);
        run_to(195);
        chk("win_link_bad_clear", 32'(lb1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
